// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction prefetcher feeding a DEPTH-entry {pc, instr} queue to decode.
// Ports:
//   clk, rst (async, active-low)       clock and reset
//   start                              enables new memory requests
//   imem_req_o/imem_addr_o/imem_data_i instruction memory, data returns one cycle after the request
//   redirect_i/redirect_addr_i         branch/jump redirect; flushes the queue and refetches from target
//   instr_o/pc_o/valid_o/ready_i       queue head handshake to decode
//   count_o                            queue occupancy
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       imem_req_o,
  output logic [31:0]                imem_addr_o,
  input  logic [31:0]                imem_data_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_addr_i,
  output logic [31:0]                instr_o,
  output logic [31:0]                pc_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic          kill;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [63:0]   mem [DEPTH];
  logic [CW:0]   credit;
  logic          push;
  logic          pop;
  // An outstanding request reserves a slot, so a response can never land in a full queue.
  always_comb begin
    credit     = {1'b0, count} + {{CW{1'b0}}, inflight};
    imem_req_o = rst & start & ~redirect_i & (credit < (CW+1)'(DEPTH));
    push       = inflight & ~kill & ~redirect_i;
    valid_o    = (count != '0) & ~redirect_i;
    pop        = valid_o & ready_i;
  end
  assign imem_addr_o     = fetch_pc;
  assign {pc_o, instr_o} = mem[rd_ptr];
  assign count_o         = count;
  // With one-cycle memory latency the stale response is already on imem_data_i during the
  // redirect cycle and is dropped there; kill marks it discarded and retires one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req_o;
      kill     <= redirect_i & inflight;
      if (redirect_i) begin
        fetch_pc <= {redirect_addr_i[31:2], 2'b00};
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (imem_req_o) fetch_pc <= fetch_pc + 32'd4;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  // Storage and the request-pc capture carry no reset; control state alone decides validity.
  always_ff @(posedge clk) begin
    if (imem_req_o) req_pc <= fetch_pc;
    if (push) mem[wr_ptr] <= {req_pc, imem_data_i};
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit against a queue-based reference model.
module tb_instr_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] K        = 32'hA5A5_0000;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  count_o;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_q[$];

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_pend = 1'b0;
    m_q.delete();
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle against the model, advance the model.
  task automatic tick(input bit s, input bit r, input bit rd, input logic [31:0] ra);
    bit e_req;
    bit e_val;
    start           = s;
    ready_i         = r;
    redirect_i      = rd;
    redirect_addr_i = ra;
    imem_data_i     = m_pend ? (m_pend_pc ^ K) : $urandom();
    @(negedge clk);
    e_req = s && !rd && (m_q.size() + int'(m_pend) < DEPTH);
    e_val = (m_q.size() != 0) && !rd;
    chk("req", {31'd0, imem_req_o}, {31'd0, e_req});
    chk("addr", imem_addr_o, m_pc);
    chk("valid", {31'd0, valid_o}, {31'd0, e_val});
    chk("count", {29'd0, count_o}, 32'(m_q.size()));
    if (e_val) begin
      chk("pc", pc_o, m_q[0]);
      chk("instr", instr_o, m_q[0] ^ K);
    end
    if (rd) begin
      m_q.delete();
      m_pc   = {ra[31:2], 2'b00};
      m_pend = 1'b0;
    end else begin
      if (e_val && r) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_pend_pc);
      m_pend = e_req;
      if (e_req) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    start      = 1'b1;
    redirect_i = 1'b0;
    ready_i    = 1'b1;
    #2;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_count", {29'd0, count_o}, 32'd0);
    chk("rst_addr", imem_addr_o, RESET_PC);
    model_reset();
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ready_i = 1'b0; redirect_i = 1'b0;
    redirect_addr_i = '0; imem_data_i = '0;
    model_reset();
    @(posedge clk);
    #1;
    // Streaming at full rate from RESET_PC
    do_reset();
    for (int i = 0; i < 12; i++) tick(1, 1, 0, '0);
    // Back-pressure fills exactly DEPTH entries, then drains in order
    do_reset();
    for (int i = 0; i < 8; i++) tick(1, 0, 0, '0);
    chk("full_count", {29'd0, count_o}, 32'd4);
    for (int i = 0; i < 6; i++) tick(0, 1, 0, '0);
    // Redirect with count=3 and a response outstanding
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 0, 0, '0);
    tick(1, 0, 1, 32'h0000_0103);
    chk("redir_count", {29'd0, count_o}, 32'd0);
    chk("redir_addr", imem_addr_o, 32'h0000_0100);
    for (int i = 0; i < 6; i++) tick(1, 1, 0, '0);
    // Redirect coincident with a decode handshake
    tick(1, 1, 1, 32'h0000_2000);
    for (int i = 0; i < 6; i++) tick(1, 1, 0, '0);
    // Fetch address wraps past the top of memory
    tick(1, 1, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) tick(1, 1, 0, '0);
    // Asynchronous reset with count=2 and a request outstanding
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 0, 0, '0);
    rst = 1'b0;
    #1;
    chk("async_valid", {31'd0, valid_o}, 32'd0);
    chk("async_count", {29'd0, count_o}, 32'd0);
    chk("async_req", {31'd0, imem_req_o}, 32'd0);
    model_reset();
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) tick(1, 1, 0, '0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 1) == 1) ? $urandom() : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
      tick($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, ra);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
